// File: rtl/xbar_pkg.sv
// Shared types and helpers for the crossbar scheduler: FSM states, select width
// and destination-field extraction from a FIFO head word.
package xbar_pkg;

  localparam int MAX_DATA_W = 256;
  localparam int MAX_SEL_W  = 5;

  typedef logic [MAX_DATA_W-1:0] word_t;
  typedef logic [MAX_SEL_W-1:0]  sel_t;

  typedef enum logic {
    ARB   = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic int sel_width(input int n);
    return $clog2(n + 1);
  endfunction

  // Callers zero-extend the head word into word_t and truncate the result to their own select width.
  function automatic sel_t dest_of(input word_t word, input int lsb, input int w);
    word_t sh;
    word_t mask;
    sh   = word >> lsb;
    mask = (word_t'(1) << w) - word_t'(1);
    return sel_t'(sh & mask);
  endfunction

endpackage

// File: rtl/xbar_scheduler_if.sv
// FIFO-head / crossbar-control bundle between the ingress FIFOs, the scheduler
// and the output muxes.
interface xbar_scheduler_if
  import xbar_pkg::*;
#(
  parameter int NPORTS = 3,
  parameter int DATA_W = 8
);
  localparam int SEL_W = sel_width(NPORTS);

  logic [NPORTS*DATA_W-1:0] data_in;
  logic [NPORTS-1:0]        empty;
  logic [NPORTS*SEL_W-1:0]  sel;
  logic [NPORTS-1:0]        en;
  logic [NPORTS-1:0]        rdreq;
  logic [NPORTS-1:0]        drop;

  // Scheduler side.
  modport master (
    input  data_in, empty,
    output sel, en, rdreq, drop
  );

  // FIFO / mux side.
  modport slave (
    output data_in, empty,
    input  sel, en, rdreq, drop
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping modulo N.
module rr_arbiter #(
  parameter  int N  = 3,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);

  always_comb begin
    int          sum;
    logic [PW-1:0] cand;
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    sum  = 0;
    cand = '0;
    for (int k = 0; k < N; k++) begin
      sum = int'(ptr) + k;
      if (sum >= N) sum = sum - N;
      cand = PW'(sum);
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/xbar_scheduler.sv
// N-port crossbar scheduler: per-output round-robin over FIFO head destinations,
// registered rdreq/sel/en/drop with an ARB/GRANT phase FSM.
module xbar_scheduler
  import xbar_pkg::*;
#(
  parameter int NPORTS       = 3,
  parameter int DATA_W       = 8,
  parameter int DEST_LSB     = 0,
  parameter int HOLD_CYCLES  = 1,
  parameter int DROP_INVALID = 0
) (
  input logic           clk,
  input logic           reset,
  xbar_scheduler_if.master bus
);

  localparam int SEL_W = sel_width(NPORTS);
  localparam int PW    = $clog2(NPORTS);

  logic [SEL_W-1:0]  dest [NPORTS];
  logic [NPORTS-1:0] req  [NPORTS];
  logic [NPORTS-1:0] gnt  [NPORTS];
  logic [PW-1:0]     win_idx [NPORTS];
  logic [NPORTS-1:0] any_gnt;
  logic [NPORTS-1:0] dreq;
  logic [NPORTS-1:0] in_gnt;

  state_t              state_reg, state_next;
  logic [3:0]          hold_cnt_reg, hold_cnt_next;
  logic [PW-1:0]       rr_reg [NPORTS];
  logic [PW-1:0]       rr_next [NPORTS];
  logic [NPORTS-1:0]   en_reg, en_next;
  logic [NPORTS*SEL_W-1:0] sel_reg, sel_next;
  logic [NPORTS-1:0]   rdreq_reg, rdreq_next;
  logic [NPORTS-1:0]   drop_reg, drop_next;

  genvar gi, gj;
  generate
    for (gi = 0; gi < NPORTS; gi++) begin : g_in
      assign dest[gi] = SEL_W'(dest_of(word_t'(bus.data_in[gi*DATA_W +: DATA_W]),
                                       DEST_LSB, SEL_W));
      // Invalid destinations are 0 or anything past the last output.
      assign dreq[gi] = (DROP_INVALID != 0) && !bus.empty[gi] &&
                        ((dest[gi] == '0) || (int'(dest[gi]) > NPORTS));
    end

    for (gi = 0; gi < NPORTS; gi++) begin : g_out
      for (gj = 0; gj < NPORTS; gj++) begin : g_req
        assign req[gi][gj] = !bus.empty[gj] && (int'(dest[gj]) == gi + 1);
      end
      rr_arbiter #(.N(NPORTS)) u_arb (
        .req (req[gi]),
        .ptr (rr_reg[gi]),
        .gnt (gnt[gi]),
        .idx (win_idx[gi]),
        .any (any_gnt[gi])
      );
    end
  endgenerate

  // Each input requests at most one output, so OR-ing per-output grants is conflict free.
  always_comb begin
    in_gnt = '0;
    for (int o = 0; o < NPORTS; o++) in_gnt = in_gnt | gnt[o];
  end

  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = hold_cnt_reg;
    rr_next       = rr_reg;
    en_next       = en_reg;
    sel_next      = sel_reg;
    rdreq_next    = '0;
    drop_next     = '0;
    case (state_reg)
      ARB: begin
        en_next  = '0;
        sel_next = '0;
        if ((|any_gnt) || (|dreq)) begin
          rdreq_next = in_gnt | dreq;
          drop_next  = dreq;
          for (int o = 0; o < NPORTS; o++) begin
            if (any_gnt[o]) begin
              en_next[o]                 = 1'b1;
              sel_next[o*SEL_W +: SEL_W] = SEL_W'(int'(win_idx[o]) + 1);
              rr_next[o] = (win_idx[o] == PW'(NPORTS - 1)) ? '0 : win_idx[o] + PW'(1);
            end
          end
          hold_cnt_next = '0;
          state_next    = GRANT;
        end
      end
      GRANT: begin
        if (hold_cnt_reg == 4'(HOLD_CYCLES - 1)) begin
          en_next    = '0;
          sel_next   = '0;
          state_next = ARB;
        end else begin
          hold_cnt_next = hold_cnt_reg + 4'd1;
        end
      end
      default: state_next = ARB;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ARB;
      hold_cnt_reg <= '0;
      en_reg       <= '0;
      sel_reg      <= '0;
      rdreq_reg    <= '0;
      drop_reg     <= '0;
      for (int o = 0; o < NPORTS; o++) rr_reg[o] <= '0;
    end else begin
      state_reg    <= state_next;
      hold_cnt_reg <= hold_cnt_next;
      en_reg       <= en_next;
      sel_reg      <= sel_next;
      rdreq_reg    <= rdreq_next;
      drop_reg     <= drop_next;
      for (int o = 0; o < NPORTS; o++) rr_reg[o] <= rr_next[o];
    end
  end

  assign bus.en    = en_reg;
  assign bus.sel   = sel_reg;
  assign bus.rdreq = rdreq_reg;
  assign bus.drop  = drop_reg;

endmodule

// File: tb/tb_xbar_scheduler.sv
// Directed bench for xbar_scheduler: three instances cover the default build,
// invalid-destination flushing and a 3-cycle hold.
module tb_xbar_scheduler;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  xbar_scheduler_if #(.NPORTS(3), .DATA_W(8)) bus_a ();
  xbar_scheduler_if #(.NPORTS(3), .DATA_W(8)) bus_b ();
  xbar_scheduler_if #(.NPORTS(3), .DATA_W(8)) bus_c ();

  xbar_scheduler #(.NPORTS(3), .DATA_W(8), .DEST_LSB(0), .HOLD_CYCLES(1), .DROP_INVALID(0))
    dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  xbar_scheduler #(.NPORTS(3), .DATA_W(8), .DEST_LSB(0), .HOLD_CYCLES(1), .DROP_INVALID(1))
    dut_b (.clk(clk), .reset(reset), .bus(bus_b));
  xbar_scheduler #(.NPORTS(3), .DATA_W(8), .DEST_LSB(0), .HOLD_CYCLES(3), .DROP_INVALID(0))
    dut_c (.clk(clk), .reset(reset), .bus(bus_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output word layout: drop[14:12] rdreq[11:9] en[8:6] sel[5:0] ({sel3,sel2,sel1}).
  function automatic logic [31:0] w(input int dr, input int rd, input int e, input int s);
    return 32'((dr << 12) | (rd << 9) | (e << 6) | s);
  endfunction

  function automatic logic [31:0] obs_a();
    return 32'({bus_a.drop, bus_a.rdreq, bus_a.en, bus_a.sel});
  endfunction
  function automatic logic [31:0] obs_b();
    return 32'({bus_b.drop, bus_b.rdreq, bus_b.en, bus_b.sel});
  endfunction
  function automatic logic [31:0] obs_c();
    return 32'({bus_c.drop, bus_c.rdreq, bus_c.en, bus_c.sel});
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    $display("check %-14s observed=%04h expected=%04h", tag, observed, expected);
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%04h expected=%04h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus_a.data_in = '0; bus_a.empty = 3'b111;
    bus_b.data_in = '0; bus_b.empty = 3'b111;
    bus_c.data_in = '0; bus_c.empty = 3'b111;
    repeat (3) @(posedge clk);
    #1;
    check("reset_a", obs_a(), w(0, 0, 0, 0));
    check("reset_b", obs_b(), w(0, 0, 0, 0));
    check("reset_c", obs_c(), w(0, 0, 0, 0));
    reset = 1'b0;
    step();
    check("idle_a", obs_a(), w(0, 0, 0, 0));

    // Permutation: in0->out2, in1->out3, in2->out1.
    bus_a.data_in = 24'h01_03_02;
    bus_a.empty   = 3'b000;
    step();
    check("perm_grant", obs_a(), w(0, 7, 7, 'h27));
    bus_a.empty = 3'b111;
    step();
    check("perm_idle", obs_a(), w(0, 0, 0, 0));

    // Contention on output 1: grants rotate 1,2,3,1,2 with idle cycles between.
    bus_a.data_in = 24'h01_01_01;
    bus_a.empty   = 3'b000;
    step(); check("cont_g1", obs_a(), w(0, 1, 1, 1));
    step(); check("cont_i1", obs_a(), w(0, 0, 0, 0));
    step(); check("cont_g2", obs_a(), w(0, 2, 1, 2));
    step(); check("cont_i2", obs_a(), w(0, 0, 0, 0));
    step(); check("cont_g3", obs_a(), w(0, 4, 1, 3));
    step(); check("cont_i3", obs_a(), w(0, 0, 0, 0));
    step(); check("cont_g4", obs_a(), w(0, 1, 1, 1));
    step(); check("cont_i4", obs_a(), w(0, 0, 0, 0));
    step(); check("cont_g5", obs_a(), w(0, 2, 1, 2));
    bus_a.empty = 3'b111;
    step(); check("cont_drain", obs_a(), w(0, 0, 0, 0));

    // Empty masking: in0 holds dest 2 but is empty.
    bus_a.data_in = 24'h00_00_02;
    for (int k = 0; k < 10; k++) begin
      step();
      check("mask_hold", obs_a(), w(0, 0, 0, 0));
    end
    bus_a.empty = 3'b110;
    step(); check("mask_grant", obs_a(), w(0, 1, 2, 'h04));
    bus_a.empty = 3'b111;
    step(); check("mask_idle", obs_a(), w(0, 0, 0, 0));

    // Async reset mid-GRANT, pointer of output 1 must return to 0.
    bus_a.data_in = 24'h01_01_01;
    bus_a.empty   = 3'b000;
    step(); check("pre_rst_g1", obs_a(), w(0, 4, 1, 3));
    step(); check("pre_rst_i1", obs_a(), w(0, 0, 0, 0));
    step(); check("pre_rst_g2", obs_a(), w(0, 1, 1, 1));
    #2 reset = 1'b1;
    #1 check("async_rst", obs_a(), w(0, 0, 0, 0));
    #3 reset = 1'b0;
    step(); check("post_rst_g", obs_a(), w(0, 1, 1, 1));
    bus_a.empty = 3'b111;
    step(); check("post_rst_i", obs_a(), w(0, 0, 0, 0));

    // Invalid destination: flushed when enabled, blocks forever otherwise.
    bus_a.data_in = 24'h00_00_00; bus_a.empty = 3'b110;
    bus_b.data_in = 24'h00_00_00; bus_b.empty = 3'b110;
    step();
    check("drop_b", obs_b(), w(1, 1, 0, 0));
    check("nodrop_a", obs_a(), w(0, 0, 0, 0));
    bus_b.empty = 3'b111;
    step();
    check("drop_b_clr", obs_b(), w(0, 0, 0, 0));
    for (int k = 0; k < 6; k++) begin
      step();
      check("block_a", obs_a(), w(0, 0, 0, 0));
    end
    bus_a.empty = 3'b111;

    // Hold of 3: en/sel stay 3 cycles, inputs ignored, then one ARB cycle.
    bus_c.data_in = 24'h00_01_00;
    bus_c.empty   = 3'b101;
    step(); check("hold_g",  obs_c(), w(0, 2, 1, 2));
    step(); check("hold_h1", obs_c(), w(0, 0, 1, 2));
    step(); check("hold_h2", obs_c(), w(0, 0, 1, 2));
    step(); check("hold_arb", obs_c(), w(0, 0, 0, 0));
    step(); check("hold_g2", obs_c(), w(0, 2, 1, 2));
    bus_c.empty = 3'b111;
    repeat (3) step();
    check("hold_end", obs_c(), w(0, 0, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
